// File: rtl/rvfi_monitor_pkg.sv
// Shared types and helpers for the RVFI/HTIF commit monitor.
package rvfi_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } htif_fsm_e;

   localparam logic [31:0] EOT_TIMEOUT = 32'hFFFF_FFFF;

   typedef struct packed {
      int unsigned NrCommitPorts;
      int unsigned XLEN;
      int unsigned PLEN;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_default = '{NrCommitPorts: 2, XLEN: 64, PLEN: 56};

   typedef struct packed {
      logic        valid;
      logic        trap;
      logic [63:0] mem_paddr;
      logic [7:0]  mem_wmask;
      logic [63:0] mem_wdata;
   } rvfi_commit_t;

   // Non-zero store by a retired, non-trapping instruction to an enabled tohost address.
   function automatic logic tohost_hit(input logic        valid,
                                       input logic        trap,
                                       input logic [7:0]  wmask,
                                       input logic [63:0] paddr,
                                       input logic [63:0] wdata,
                                       input logic [63:0] tohost);
      return valid & ~trap & (|wmask) & (paddr == tohost) & (|tohost) & (|wdata);
   endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module fifo_v3 #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  flush_i,
   output logic                  full_o,
   output logic                  empty_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam int unsigned AddrW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AddrW-1:0]      rd_q, wr_q;
   logic [AddrW:0]        cnt_q;
   logic                  do_push, do_pop;

   assign full_o  = (cnt_q == (AddrW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rd_q];
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i) begin
      if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AddrW'(1);
         if (do_pop)  rd_q <= rd_q + AddrW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (AddrW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AddrW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!flush_i && do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/rvfi_htif_monitor.sv
// Watches the commit bus for tohost stores: latches the exit code or queues syscalls for a host agent,
// with a timeout watchdog and retire/trap counters.
module rvfi_htif_monitor
   import rvfi_monitor_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg      = cva6_cfg_default,
   parameter type         rvfi_instr_t = rvfi_commit_t,
   parameter int unsigned SyscallDepth = 4,
   parameter int unsigned CntWidth     = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  rvfi_instr_t               rvfi_i [CVA6Cfg.NrCommitPorts],
   input  logic [CVA6Cfg.PLEN-1:0]   tohost_addr_i,
   input  logic [CntWidth-1:0]       timeout_cycles_i,
   output logic                      syscall_valid_o,
   output logic [63:0]               syscall_data_o,
   input  logic                      syscall_ready_i,
   input  logic                      syscall_done_i,
   output logic                      syscall_busy_o,
   output logic [31:0]               end_of_test_o,
   output logic [CntWidth-1:0]       instret_o,
   output logic [31:0]               trap_count_o,
   output logic [1:0]                error_o
);

   localparam int unsigned NrPorts = CVA6Cfg.NrCommitPorts;
   localparam int unsigned PopW    = $clog2(NrPorts + 1);

   logic [NrPorts-1:0] hit_vec;
   logic               hit_any, hit_multi;
   logic [63:0]        hit_data;
   logic [PopW-1:0]    ret_cnt, trap_cnt;

   always_comb begin
      hit_vec   = '0;
      hit_any   = 1'b0;
      hit_multi = 1'b0;
      hit_data  = '0;
      ret_cnt   = '0;
      trap_cnt  = '0;
      for (int unsigned i = 0; i < NrPorts; i++) begin
         hit_vec[i] = tohost_hit(rvfi_i[i].valid, rvfi_i[i].trap, rvfi_i[i].mem_wmask,
                                 rvfi_i[i].mem_paddr, rvfi_i[i].mem_wdata, 64'(tohost_addr_i));
         ret_cnt  = ret_cnt + PopW'(rvfi_i[i].valid & ~rvfi_i[i].trap);
         trap_cnt = trap_cnt + PopW'(rvfi_i[i].valid & rvfi_i[i].trap);
      end
      // Oldest port wins; any younger hit in the same cycle is reported and dropped.
      for (int unsigned i = 0; i < NrPorts; i++) begin
         if (hit_vec[i]) begin
            if (hit_any) begin
               hit_multi = 1'b1;
            end else begin
               hit_any  = 1'b1;
               hit_data = rvfi_i[i].mem_wdata;
            end
         end
      end
   end

   logic exit_hit, sys_hit;
   assign exit_hit = hit_any & hit_data[0];
   assign sys_hit  = hit_any & ~hit_data[0];

   logic                fifo_full, fifo_empty, fifo_pop;
   logic [63:0]         fifo_head;

   fifo_v3 #(
      .DATA_WIDTH (64),
      .DEPTH      (SyscallDepth)
   ) i_syscall_fifo (
      .clk_i   (clk_i),
      .flush_i (rst_i),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .data_i  (hit_data),
      .push_i  (sys_hit),
      .data_o  (fifo_head),
      .pop_i   (fifo_pop)
   );

   htif_fsm_e state_q, state_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      fifo_pop        = 1'b0;
      syscall_valid_o = 1'b0;
      unique case (state_q)
         IDLE: if (!fifo_empty) state_d = REQ;
         REQ: begin
            syscall_valid_o = 1'b1;
            if (syscall_ready_i) begin
               fifo_pop = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: if (syscall_done_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign syscall_data_o = syscall_valid_o ? fifo_head : '0;
   assign syscall_busy_o = (state_q != IDLE);

   logic [CntWidth-1:0] cycle_q, instret_q;
   logic [31:0]         eot_q, trap_q;
   logic [1:0]          err_q;
   logic [32:0]         trap_sum;
   logic                timeout_hit;

   assign trap_sum    = {1'b0, trap_q} + 33'(trap_cnt);
   assign timeout_hit = (timeout_cycles_i != '0) && (cycle_q >= timeout_cycles_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cycle_q   <= '0;
         instret_q <= '0;
         trap_q    <= '0;
         eot_q     <= '0;
         err_q     <= '0;
      end else begin
         if (~&cycle_q) cycle_q <= cycle_q + CntWidth'(1);
         instret_q <= instret_q + CntWidth'(ret_cnt);
         trap_q    <= trap_sum[32] ? '1 : trap_sum[31:0];
         if (eot_q == '0) begin
            if (exit_hit)         eot_q <= hit_data[31:0];
            else if (timeout_hit) eot_q <= EOT_TIMEOUT;
         end
         if (sys_hit && fifo_full && !fifo_pop) err_q[0] <= 1'b1;
         if (hit_multi)                         err_q[1] <= 1'b1;
      end
   end

   assign end_of_test_o = eot_q;
   assign instret_o     = instret_q;
   assign trap_count_o  = trap_q;
   assign error_o       = err_q;

endmodule

// File: tb/tb_rvfi_htif_monitor.sv
// Directed bench for rvfi_htif_monitor with a scoreboard queue of expected syscall payloads.
module tb_rvfi_htif_monitor;
   import rvfi_monitor_pkg::*;

   localparam logic [55:0] TOHOST = 56'h8000_1000;

   logic         clk = 1'b0;
   logic         rst;
   rvfi_commit_t rvfi [2];
   logic [55:0]  tohost;
   logic [63:0]  timeout;
   logic         syscall_valid, syscall_ready, syscall_done, syscall_busy;
   logic [63:0]  syscall_data;
   logic [31:0]  eot;
   logic [63:0]  instret;
   logic [31:0]  trap_count;
   logic [1:0]   error;

   int unsigned  n_assert = 0;
   int unsigned  n_fail   = 0;
   logic [63:0]  sb [$];

   always #5 clk = ~clk;

   rvfi_htif_monitor #(
      .CVA6Cfg      (cva6_cfg_default),
      .rvfi_instr_t (rvfi_commit_t),
      .SyscallDepth (4),
      .CntWidth     (64)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .rvfi_i           (rvfi),
      .tohost_addr_i    (tohost),
      .timeout_cycles_i (timeout),
      .syscall_valid_o  (syscall_valid),
      .syscall_data_o   (syscall_data),
      .syscall_ready_i  (syscall_ready),
      .syscall_done_i   (syscall_done),
      .syscall_busy_o   (syscall_busy),
      .end_of_test_o    (eot),
      .instret_o        (instret),
      .trap_count_o     (trap_count),
      .error_o          (error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_ports();
      for (int i = 0; i < 2; i++) rvfi[i] = '0;
   endtask

   task automatic set_store(input int port, input logic [63:0] data);
      rvfi[port] = '{valid: 1'b1, trap: 1'b0, mem_paddr: 64'(TOHOST), mem_wmask: 8'hFF, mem_wdata: data};
   endtask

   task automatic store(input logic [63:0] data);
      set_store(0, data);
      tick();
      clear_ports();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic wait_valid(input string tag);
      int unsigned k = 0;
      while (!syscall_valid && k < 50) begin
         tick();
         k++;
      end
      check({tag, "_valid"}, 64'(syscall_valid), 64'd1);
   endtask

   task automatic deliver(input string tag);
      logic [63:0] exp;
      wait_valid(tag);
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      check({tag, "_data"}, syscall_data, exp);
      syscall_ready = 1'b1;
      tick();
      syscall_ready = 1'b0;
      check({tag, "_wait_busy"}, 64'(syscall_busy), 64'd1);
      check({tag, "_wait_valid"}, 64'(syscall_valid), 64'd0);
      syscall_done = 1'b1;
      tick();
      syscall_done = 1'b0;
      check({tag, "_idle_busy"}, 64'(syscall_busy), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      tohost = TOHOST;
      timeout = '0;
      syscall_ready = 1'b0;
      syscall_done = 1'b0;
      clear_ports();
      do_reset();
      check("rst_eot", 64'(eot), 64'd0);
      check("rst_valid", 64'(syscall_valid), 64'd0);
      check("rst_data", syscall_data, 64'd0);
      check("rst_busy", 64'(syscall_busy), 64'd0);
      check("rst_instret", instret, 64'd0);
      check("rst_trap", 64'(trap_count), 64'd0);
      check("rst_error", 64'(error), 64'd0);

      // 1: exit code with one-cycle latency, sticky against a later exit store
      set_store(0, 64'h1);
      check("t1_eot_before", 64'(eot), 64'd0);
      tick();
      clear_ports();
      check("t1_eot", 64'(eot), 64'h1);
      store(64'h3);
      check("t1_eot_sticky", 64'(eot), 64'h1);

      // 2: single syscall held by the host
      store(64'h8000_2000);
      sb.push_back(64'h8000_2000);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_valid", 64'(syscall_valid), 64'd1);
         check("t2_hold_data", syscall_data, 64'h8000_2000);
         tick();
      end
      deliver("t2");
      syscall_done = 1'b1;
      tick();
      syscall_done = 1'b0;
      check("t2_done_in_idle", 64'(syscall_busy), 64'd0);

      // 3: overflow of a 4-deep queue
      for (int i = 1; i <= 5; i++) begin
         store(64'(i * 16));
         if (i <= 4) sb.push_back(64'(i * 16));
      end
      check("t3_overflow_err", 64'(error), 64'b01);
      for (int i = 0; i < 4; i++) deliver("t3");
      repeat (5) tick();
      check("t3_drained_valid", 64'(syscall_valid), 64'd0);
      check("t3_drained_busy", 64'(syscall_busy), 64'd0);

      // 4: two hits in one cycle, only the oldest port is taken
      do_reset();
      set_store(0, 64'h2);
      set_store(1, 64'h4);
      sb.push_back(64'h2);
      tick();
      clear_ports();
      check("t4_multi_err", 64'(error), 64'b10);
      deliver("t4");
      repeat (5) tick();
      check("t4_no_second", 64'(syscall_valid), 64'd0);
      check("t4_eot", 64'(eot), 64'd0);

      // 5: watchdog at 100 cycles, then exit code winning the same cycle
      timeout = 64'd100;
      do_reset();
      repeat (100) tick();
      check("t5_eot_at_limit", 64'(eot), 64'd0);
      tick();
      check("t5_timeout", 64'(eot), 64'hFFFF_FFFF);
      do_reset();
      repeat (100) tick();
      store(64'h5);
      check("t5_exit_wins", 64'(eot), 64'h5);
      timeout = '0;

      // 6: retire/trap counting, then reset in the middle of a syscall
      do_reset();
      for (int i = 0; i < 10; i++) begin
         rvfi[0] = '{valid: 1'b1, trap: 1'b0, mem_paddr: '0, mem_wmask: '0, mem_wdata: '0};
         rvfi[1] = '{valid: 1'b1, trap: 1'b0, mem_paddr: 64'(TOHOST), mem_wmask: '0, mem_wdata: 64'h8};
         tick();
      end
      clear_ports();
      rvfi[0] = '{valid: 1'b1, trap: 1'b1, mem_paddr: 64'(TOHOST), mem_wmask: 8'hFF, mem_wdata: 64'h6};
      tick();
      clear_ports();
      check("t6_instret", instret, 64'd20);
      check("t6_trap", 64'(trap_count), 64'd1);
      check("t6_no_hit", 64'(syscall_busy), 64'd0);
      store(64'h100);
      sb.push_back(64'h100);
      wait_valid("t6");
      check("t6_data", syscall_data, sb.pop_front());
      syscall_ready = 1'b1;
      tick();
      syscall_ready = 1'b0;
      store(64'h200);
      check("t6_busy_wait", 64'(syscall_busy), 64'd1);
      do_reset();
      check("t6_rst_eot", 64'(eot), 64'd0);
      check("t6_rst_busy", 64'(syscall_busy), 64'd0);
      check("t6_rst_instret", instret, 64'd0);
      check("t6_rst_trap", 64'(trap_count), 64'd0);
      check("t6_rst_error", 64'(error), 64'd0);
      repeat (5) tick();
      check("t6_fifo_flushed", 64'(syscall_valid), 64'd0);
      check("t6_fifo_flushed_busy", 64'(syscall_busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
